ahbl_arbiter_2: RTL and testbench
=================================

// Module: ahbl_arbiter_2
// PURPOSE
//  Two-master AHB-Lite arbiter: shares one AHB-Lite bus (splitter + PMEM/DMEM/GPIO) between M0 (Hazard2 CPU)
//  and M1 (DMA/debug master). Sits between the masters and the address splitter. An uncontended request
//  passes through in the same cycle. A losing request is captured in a 1-deep per-master buffer and replayed
//  later; the loser is held in wait states until the replay completes.
// PARAMETERS
//  PRIORITY_MODE  0   0 = round-robin between M0/M1; 1 = fixed priority, M0 always wins contests
// PORTS
//  HCLK        in   1   clock; single clock domain
//  HRESET      in   1   reset, synchronous, active-high
//  M0_HADDR    in   32  M0 address phase (M1_* identical set for master 1)
//  M0_HTRANS   in   2   M0 transfer type
//  M0_HSIZE    in   3   M0 size
//  M0_HWRITE   in   1   M0 direction
//  M0_HWDATA   in   32  M0 write data (data phase)
//  M0_HREADY   out  1   M0 ready (see BEHAVIOUR)
//  M0_HRDATA   out  32  = HRDATA (broadcast)
//  HADDR/HTRANS/HSIZE/HWRITE  out  32/2/3/1  arbitrated address phase to splitter and slaves
//  HWDATA      out  32  write data of data-phase owner
//  HREADY      in   1   bus ready from splitter
//  HRDATA      in   32  bus read data from splitter
//  HMASTER     out  1   master owning current address phase (gnt)
// BEHAVIOUR
//  - Active = HTRANS[1] (NONSEQ/SEQ). IDLE/BUSY never request, are never captured; SEQ is arbitrated as NONSEQ.
//  - State: pend[m] + buffered {addr,trans,size,write} per master; gnt_q; dph_v, dph_own; last (RR pointer).
//  - req[m] = pend[m] | (M*_HREADY==1 & live HTRANS[1]).
//  - gnt: if HREADY=1, combinational arbitration over req. Single requester wins. Both: RR -> ~last;
//    fixed -> M0. None -> gnt_q. If HREADY=0, gnt = gnt_q (frozen).
//  - Output address phase = buffered request of gnt if pend[gnt]. Else live signals of gnt if HREADY=1 and
//    M_gnt_HREADY=1. Else IDLE (addr=0, size=0, write=0). Output is stable during HREADY=0; only IDLE->NONSEQ
//    is allowed mid-wait (buffer filled by capture).
//  - Capture at edge: M*_HREADY=1 & live active & not (gnt==m & HREADY=1 & ~pend[m]) -> pend[m]<=1, regs
//    <= live.
//  - Release: pend[m] clears at the edge where gnt==m & HREADY=1.
//  - Edge with HREADY=1: dph_v <= HTRANS[1]; dph_own <= gnt; gnt_q <= gnt; if HTRANS[1], last <= gnt.
//  - M*_HREADY: (dph_v & dph_own==m) ? HREADY : (pend[m] ? 0 : 1). HWDATA = dph_own ? M1_HWDATA : M0_HWDATA.
//    A stalled master holds HWDATA valid per AHB rules.
//  - Latency: uncontended = 0 added cycles. Buffered loser = +1 cycle minimum, plus winner's wait states.
//    RR bounds starvation to one transfer.
//  - Reset: pend=0, dph_v=0, dph_own=0, gnt_q=0, last=1 (M0 wins first tie). While HRESET=1, outputs are
//    forced HTRANS=IDLE, HADDR=0, HMASTER=0, M*_HREADY=1. Reset mid-transfer drops buffered requests without
//    replay.
//  - Simultaneous data-phase completion and new capture by the same master: the new request is captured;
//    M*_HREADY falls next cycle.
// STRUCTURE
//  - Shared package ahbl_pkg: HTRANS_IDLE/BUSY/NONSEQ/SEQ constants and the addr-phase bundle width (38b).
//  - Sub-module ahbl_arb_req_buf: capture/release register for one master's address phase. Instantiated
//    twice. Arbitration, gnt and data-phase tracking stay in the top.
// TESTING
//  1. Idle bus, M0 NONSEQ read 0x2000_0010 -> HADDR=0x2000_0010 same cycle, HMASTER=0; M0_HREADY follows
//     HREADY next cycle; 0 extra waits.
//  2. Same cycle M0 read 0x0000_0100 and M1 write 0x2000_0000 with 0xA5A5_5A5A, after reset ->
//     M0 forwarded, M1 pend; next cycle HADDR=0x2000_0000, HMASTER=1; HWDATA=0xA5A5_5A5A in M1 data phase;
//     M1_HREADY low exactly 1 cycle.
//  3. HREADY low 3 cycles in M0 data phase while M1 issues NONSEQ 0x4000_0000 -> captured;
//     HTRANS IDLE->NONSEQ at most once and stable for the rest of the wait; M1 granted on first HREADY=1.
//  4. Both masters back-to-back NONSEQ x8, PRIORITY_MODE=0 -> grants alternate M0,M1,...; 4 each.
//     PRIORITY_MODE=1 -> M0 wins every contest; M1 served only when M0 IDLE.
//  5. M1 pending, assert HRESET 1 cycle -> next cycle HTRANS=IDLE, M0/M1_HREADY=1, pend cleared; no replay.
//  6. M0 issues BUSY and IDLE while M1 idle -> no capture; HTRANS out IDLE; M0_HREADY stays 1.

Source files
------------

// File: rtl/ahbl_pkg.sv
// Shared AHB-Lite definitions for the two-master arbiter: transfer-type codes
// and the packed address-phase bundle that is buffered and replayed per master.
package ahbl_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam int APH_W = 38;

    typedef struct packed {
        logic [31:0] addr;
        logic [1:0]  trans;
        logic [2:0]  size;
        logic        write;
    } aph_t;

    localparam aph_t APH_IDLE = '{addr: 32'h0, trans: HTRANS_IDLE, size: 3'd0, write: 1'b0};

    // NONSEQ and SEQ request the bus; IDLE and BUSY never do.
    function automatic logic is_active(input logic [1:0] trans);
        return trans[1];
    endfunction

endpackage

// File: rtl/ahbl_arb_req_buf.sv
// One-deep holding register for a master's address phase that lost arbitration
// or arrived while the bus was stalled; held until the arbiter issues it.
module ahbl_arb_req_buf
    import ahbl_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             capture_i,
    input  logic             release_i,
    input  logic [APH_W-1:0] aph_i,
    output logic             pend_o,
    output logic [APH_W-1:0] aph_o
);

    logic             pend_q, pend_d;
    logic [APH_W-1:0] aph_q, aph_d;

    // A new capture in the same cycle as a release replaces the issued entry.
    always_comb begin
        pend_d = pend_q;
        aph_d  = aph_q;
        if (capture_i) begin
            pend_d = 1'b1;
            aph_d  = aph_i;
        end else if (release_i) begin
            pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pend_q <= 1'b0;
            aph_q  <= '0;
        end else begin
            pend_q <= pend_d;
            aph_q  <= aph_d;
        end
    end

    assign pend_o = pend_q;
    assign aph_o  = aph_q;

endmodule

// File: rtl/ahbl_arbiter_2.sv
// Two-master AHB-Lite arbiter: uncontended requests pass through in the same
// cycle, losers are buffered and replayed while their master is held in wait.
module ahbl_arbiter_2
    import ahbl_pkg::*;
#(
    parameter int PRIORITY_MODE = 0
) (
    input  logic        hclk_i,
    input  logic        hreset_i,

    input  logic [31:0] m0_haddr_i,
    input  logic [1:0]  m0_htrans_i,
    input  logic [2:0]  m0_hsize_i,
    input  logic        m0_hwrite_i,
    input  logic [31:0] m0_hwdata_i,
    output logic        m0_hready_o,
    output logic [31:0] m0_hrdata_o,

    input  logic [31:0] m1_haddr_i,
    input  logic [1:0]  m1_htrans_i,
    input  logic [2:0]  m1_hsize_i,
    input  logic        m1_hwrite_i,
    input  logic [31:0] m1_hwdata_i,
    output logic        m1_hready_o,
    output logic [31:0] m1_hrdata_o,

    output logic [31:0] haddr_o,
    output logic [1:0]  htrans_o,
    output logic [2:0]  hsize_o,
    output logic        hwrite_o,
    output logic [31:0] hwdata_o,
    input  logic        hready_i,
    input  logic [31:0] hrdata_i,
    output logic        hmaster_o
);

    aph_t             live0, live1;
    aph_t             buf0, buf1;
    logic [APH_W-1:0] buf0_raw, buf1_raw;
    logic [1:0]       pend, mready, live_act, req, capture, release_req;
    logic             gnt;
    aph_t             aph_out;

    logic gnt_q, gnt_d;
    logic dph_v_q, dph_v_d;
    logic dph_own_q, dph_own_d;
    logic last_q, last_d;

    assign live0 = '{addr: m0_haddr_i, trans: m0_htrans_i, size: m0_hsize_i, write: m0_hwrite_i};
    assign live1 = '{addr: m1_haddr_i, trans: m1_htrans_i, size: m1_hsize_i, write: m1_hwrite_i};
    assign buf0  = aph_t'(buf0_raw);
    assign buf1  = aph_t'(buf1_raw);

    // A master sees the bus ready during its own data phase, and is stalled
    // while its buffered request waits to be issued.
    always_comb begin
        mready[0]   = (dph_v_q && !dph_own_q) ? hready_i : !pend[0];
        mready[1]   = (dph_v_q &&  dph_own_q) ? hready_i : !pend[1];
        live_act[0] = is_active(live0.trans);
        live_act[1] = is_active(live1.trans);
        req         = pend | (mready & live_act);
    end

    always_comb begin
        gnt = gnt_q;
        if (hready_i) begin
            case (req)
                2'b01:   gnt = 1'b0;
                2'b10:   gnt = 1'b1;
                2'b11:   gnt = (PRIORITY_MODE != 0) ? 1'b0 : !last_q;
                default: gnt = gnt_q;
            endcase
        end
    end

    always_comb begin
        aph_out = APH_IDLE;
        if (gnt ? pend[1] : pend[0]) begin
            aph_out = gnt ? buf1 : buf0;
        end else if (hready_i && (gnt ? (mready[1] && live_act[1]) : (mready[0] && live_act[0]))) begin
            aph_out = gnt ? live1 : live0;
        end
        if (hreset_i) begin
            aph_out = APH_IDLE;
        end
    end

    // Capture every accepted-looking request that is not going out right now.
    always_comb begin
        capture[0]     = mready[0] && live_act[0] && !(!gnt && hready_i && !pend[0]);
        capture[1]     = mready[1] && live_act[1] && !( gnt && hready_i && !pend[1]);
        release_req[0] = !gnt && hready_i;
        release_req[1] =  gnt && hready_i;
    end

    ahbl_arb_req_buf u_buf_m0 (
        .clk_i     (hclk_i),
        .rst_i     (hreset_i),
        .capture_i (capture[0]),
        .release_i (release_req[0]),
        .aph_i     (live0),
        .pend_o    (pend[0]),
        .aph_o     (buf0_raw)
    );

    ahbl_arb_req_buf u_buf_m1 (
        .clk_i     (hclk_i),
        .rst_i     (hreset_i),
        .capture_i (capture[1]),
        .release_i (release_req[1]),
        .aph_i     (live1),
        .pend_o    (pend[1]),
        .aph_o     (buf1_raw)
    );

    always_comb begin
        gnt_d     = gnt_q;
        dph_v_d   = dph_v_q;
        dph_own_d = dph_own_q;
        last_d    = last_q;
        if (hready_i) begin
            gnt_d     = gnt;
            dph_v_d   = is_active(aph_out.trans);
            dph_own_d = gnt;
            if (is_active(aph_out.trans)) begin
                last_d = gnt;
            end
        end
    end

    // last starts at M1 so the first tie after reset goes to M0.
    always_ff @(posedge hclk_i) begin
        if (hreset_i) begin
            gnt_q     <= 1'b0;
            dph_v_q   <= 1'b0;
            dph_own_q <= 1'b0;
            last_q    <= 1'b1;
        end else begin
            gnt_q     <= gnt_d;
            dph_v_q   <= dph_v_d;
            dph_own_q <= dph_own_d;
            last_q    <= last_d;
        end
    end

    assign haddr_o     = aph_out.addr;
    assign htrans_o    = aph_out.trans;
    assign hsize_o     = aph_out.size;
    assign hwrite_o    = aph_out.write;
    assign hmaster_o   = hreset_i ? 1'b0 : gnt;
    assign hwdata_o    = dph_own_q ? m1_hwdata_i : m0_hwdata_i;
    assign m0_hready_o = hreset_i | mready[0];
    assign m1_hready_o = hreset_i | mready[1];
    assign m0_hrdata_o = hrdata_i;
    assign m1_hrdata_o = hrdata_i;

endmodule

// File: tb/tb_ahbl_arbiter_2.sv
// Bench for ahbl_arbiter_2: single-cycle vector table from reset, hand-written
// multi-cycle scenarios, and random traffic against a transaction-level model.
module tb_ahbl_arbiter_2;

    localparam logic [1:0] T_IDLE = 2'b00, T_BUSY = 2'b01, T_NS = 2'b10, T_SEQ = 2'b11;

    logic        clk = 1'b0;
    logic        rst;
    logic        hready;
    logic [31:0] hrdata;
    logic [31:0] m_haddr  [2];
    logic [1:0]  m_htrans [2];
    logic [2:0]  m_hsize  [2];
    logic        m_hwrite [2];
    logic [31:0] m_hwdata [2];

    logic [1:0]  rr_rdy, fp_rdy;
    logic [31:0] rr_rd0, rr_rd1, fp_rd0, fp_rd1;
    logic [31:0] rr_haddr, fp_haddr, rr_hwdata, fp_hwdata;
    logic [1:0]  rr_htrans, fp_htrans;
    logic [2:0]  rr_hsize, fp_hsize;
    logic        rr_hwrite, fp_hwrite, rr_hmaster, fp_hmaster;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ahbl_arbiter_2 #(.PRIORITY_MODE(0)) u_rr (
        .hclk_i(clk), .hreset_i(rst),
        .m0_haddr_i(m_haddr[0]), .m0_htrans_i(m_htrans[0]), .m0_hsize_i(m_hsize[0]),
        .m0_hwrite_i(m_hwrite[0]), .m0_hwdata_i(m_hwdata[0]), .m0_hready_o(rr_rdy[0]), .m0_hrdata_o(rr_rd0),
        .m1_haddr_i(m_haddr[1]), .m1_htrans_i(m_htrans[1]), .m1_hsize_i(m_hsize[1]),
        .m1_hwrite_i(m_hwrite[1]), .m1_hwdata_i(m_hwdata[1]), .m1_hready_o(rr_rdy[1]), .m1_hrdata_o(rr_rd1),
        .haddr_o(rr_haddr), .htrans_o(rr_htrans), .hsize_o(rr_hsize), .hwrite_o(rr_hwrite),
        .hwdata_o(rr_hwdata), .hready_i(hready), .hrdata_i(hrdata), .hmaster_o(rr_hmaster)
    );

    ahbl_arbiter_2 #(.PRIORITY_MODE(1)) u_fp (
        .hclk_i(clk), .hreset_i(rst),
        .m0_haddr_i(m_haddr[0]), .m0_htrans_i(m_htrans[0]), .m0_hsize_i(m_hsize[0]),
        .m0_hwrite_i(m_hwrite[0]), .m0_hwdata_i(m_hwdata[0]), .m0_hready_o(fp_rdy[0]), .m0_hrdata_o(fp_rd0),
        .m1_haddr_i(m_haddr[1]), .m1_htrans_i(m_htrans[1]), .m1_hsize_i(m_hsize[1]),
        .m1_hwrite_i(m_hwrite[1]), .m1_hwdata_i(m_hwdata[1]), .m1_hready_o(fp_rdy[1]), .m1_hrdata_o(fp_rd1),
        .haddr_o(fp_haddr), .htrans_o(fp_htrans), .hsize_o(fp_hsize), .hwrite_o(fp_hwrite),
        .hwdata_o(fp_hwdata), .hready_i(hready), .hrdata_i(hrdata), .hmaster_o(fp_hmaster)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic set_m(input int m, input logic [1:0] t, input logic [31:0] a, input logic w);
        m_htrans[m] = t;
        m_haddr[m]  = a;
        m_hwrite[m] = w;
        m_hsize[m]  = 3'd2;
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        hready = 1'b1;
        set_m(0, T_IDLE, 32'h0, 1'b0);
        set_m(1, T_IDLE, 32'h0, 1'b0);
        cyc();
        rst = 1'b0;
    endtask

    // ---------------- single-cycle vectors, each from a fresh reset ----------------
    typedef struct {
        logic [1:0]  t0;
        logic [31:0] a0;
        logic [1:0]  t1;
        logic [31:0] a1;
        logic        hr;
        logic [1:0]  e_trans;
        logic [31:0] e_addr;
        logic        e_mst;
    } vec_t;

    function automatic vec_t mkv(logic [1:0] t0, logic [31:0] a0, logic [1:0] t1, logic [31:0] a1,
                                 logic hr, logic [1:0] et, logic [31:0] ea, logic em);
        vec_t v;
        v.t0 = t0; v.a0 = a0; v.t1 = t1; v.a1 = a1; v.hr = hr;
        v.e_trans = et; v.e_addr = ea; v.e_mst = em;
        return v;
    endfunction

    // ---------------- behavioural reference model ----------------
    typedef struct packed {
        logic [31:0] a;
        logic [1:0]  t;
        logic [2:0]  s;
        logic        w;
    } req_t;

    req_t held0[$];
    req_t held1[$];
    bit   dp_busy;
    int   dp_who, prev_w, last_w;
    bit   acc [2];

    task automatic model_reset();
        held0.delete();
        held1.delete();
        dp_busy = 1'b0;
        dp_who  = 0;
        prev_w  = 0;
        last_w  = 1;
    endtask

    task automatic rand_cycle();
        req_t lv [2];
        bit   act [2], rdy [2], want [2];
        int   nheld [2];
        int   w;
        req_t iss;
        bit   hadp;
        nheld[0] = held0.size();
        nheld[1] = held1.size();
        for (int m = 0; m < 2; m++) begin
            lv[m]   = '{m_haddr[m], m_htrans[m], m_hsize[m], m_hwrite[m]};
            act[m]  = m_htrans[m][1];
            rdy[m]  = (dp_busy && dp_who == m) ? hready : (nheld[m] == 0);
            want[m] = (nheld[m] > 0) || (rdy[m] && act[m]);
        end
        if (!hready)                 w = prev_w;
        else if (want[0] && want[1]) w = 1 - last_w;
        else if (want[0])            w = 0;
        else if (want[1])            w = 1;
        else                         w = prev_w;
        iss = '0;
        if (nheld[w] > 0)                       iss = (w == 0) ? held0[0] : held1[0];
        else if (hready && rdy[w] && act[w])    iss = lv[w];
        if (rst) iss = '0;

        chk("rnd htrans",  rr_htrans,  iss.t);
        chk("rnd haddr",   rr_haddr,   iss.a);
        chk("rnd hsize",   rr_hsize,   iss.s);
        chk("rnd hwrite",  rr_hwrite,  iss.w);
        chk("rnd hmaster", rr_hmaster, rst ? 0 : w);
        chk("rnd m0 rdy",  rr_rdy[0],  rst ? 1'b1 : rdy[0]);
        chk("rnd m1 rdy",  rr_rdy[1],  rst ? 1'b1 : rdy[1]);
        chk("rnd hwdata",  rr_hwdata,  (dp_who == 1) ? m_hwdata[1] : m_hwdata[0]);
        chk("rnd hrdata",  rr_rd1,     hrdata);

        if (rst) begin
            model_reset();
            acc[0] = 1'b1;
            acc[1] = 1'b1;
        end else begin
            for (int m = 0; m < 2; m++) begin
                hadp = nheld[m] > 0;
                if (hadp && w == m && hready) begin
                    if (m == 0) void'(held0.pop_front()); else void'(held1.pop_front());
                end
                if (rdy[m] && act[m] && !(w == m && hready && !hadp)) begin
                    if (m == 0) begin held0.delete(); held0.push_back(lv[m]); end
                    else        begin held1.delete(); held1.push_back(lv[m]); end
                end
                acc[m] = rdy[m];
            end
            if (hready) begin
                dp_busy = iss.t[1];
                dp_who  = w;
                prev_w  = w;
                if (iss.t[1]) last_w = w;
            end
        end
    endtask

    initial begin
        vec_t        tbl [10];
        int          n0, n1, alt_bad, fp_bad, nchg;
        logic [1:0]  prev_t;

        rst    = 1'b1;
        hready = 1'b1;
        hrdata = 32'h0;
        for (int m = 0; m < 2; m++) begin
            set_m(m, T_IDLE, 32'h0, 1'b0);
            m_hwdata[m] = 32'h0;
        end

        // reset forces the outputs even with a live request
        set_m(0, T_NS, 32'h1234_5678, 1'b1);
        #1;
        chk("rst htrans",  rr_htrans,  T_IDLE);
        chk("rst haddr",   rr_haddr,   32'h0);
        chk("rst hmaster", rr_hmaster, 0);
        chk("rst rdy",     rr_rdy,     2'b11);
        cyc();

        tbl[0] = mkv(T_IDLE, 32'h0,         T_IDLE, 32'h0,         1'b1, T_IDLE, 32'h0,         1'b0);
        tbl[1] = mkv(T_NS,   32'h2000_0010, T_IDLE, 32'h0,         1'b1, T_NS,   32'h2000_0010, 1'b0);
        tbl[2] = mkv(T_IDLE, 32'h0,         T_NS,   32'h4000_0000, 1'b1, T_NS,   32'h4000_0000, 1'b1);
        tbl[3] = mkv(T_NS,   32'h0000_0100, T_NS,   32'h0000_0200, 1'b1, T_NS,   32'h0000_0100, 1'b0);
        tbl[4] = mkv(T_BUSY, 32'h0000_0300, T_IDLE, 32'h0,         1'b1, T_IDLE, 32'h0,         1'b0);
        tbl[5] = mkv(T_SEQ,  32'h0000_0304, T_IDLE, 32'h0,         1'b1, T_SEQ,  32'h0000_0304, 1'b0);
        tbl[6] = mkv(T_NS,   32'h0000_0400, T_IDLE, 32'h0,         1'b0, T_IDLE, 32'h0,         1'b0);
        tbl[7] = mkv(T_IDLE, 32'h0,         T_NS,   32'h0000_0500, 1'b0, T_IDLE, 32'h0,         1'b0);
        tbl[8] = mkv(T_IDLE, 32'h0,         T_BUSY, 32'h0000_0600, 1'b1, T_IDLE, 32'h0,         1'b0);
        tbl[9] = mkv(T_IDLE, 32'h0,         T_SEQ,  32'h0000_0044, 1'b1, T_SEQ,  32'h0000_0044, 1'b1);

        for (int i = 0; i < 10; i++) begin
            do_reset();
            set_m(0, tbl[i].t0, tbl[i].a0, 1'b0);
            set_m(1, tbl[i].t1, tbl[i].a1, 1'b0);
            hready = tbl[i].hr;
            #1;
            chk($sformatf("vec%0d htrans", i),     rr_htrans,  tbl[i].e_trans);
            chk($sformatf("vec%0d haddr", i),      rr_haddr,   tbl[i].e_addr);
            chk($sformatf("vec%0d hmaster", i),    rr_hmaster, tbl[i].e_mst);
            chk($sformatf("vec%0d rdy", i),        rr_rdy,     2'b11);
            chk($sformatf("vec%0d fp hmaster", i), fp_hmaster, tbl[i].e_mst);
            cyc();
        end

        // uncontended pass-through, then M0 data phase follows HREADY
        do_reset();
        set_m(0, T_NS, 32'h2000_0010, 1'b0);
        #1;
        chk("pass htrans",  rr_htrans,  T_NS);
        chk("pass haddr",   rr_haddr,   32'h2000_0010);
        chk("pass hmaster", rr_hmaster, 0);
        cyc();
        set_m(0, T_IDLE, 32'h0, 1'b0);
        hready = 1'b0;
        #1;
        chk("pass dph m0 rdy low", rr_rdy[0], 1'b0);
        cyc();
        hready = 1'b1;
        #1;
        chk("pass dph m0 rdy high", rr_rdy[0], 1'b1);
        cyc();

        // simultaneous requests: M1 buffered and replayed one cycle later
        do_reset();
        set_m(0, T_NS, 32'h0000_0100, 1'b0);
        set_m(1, T_NS, 32'h2000_0000, 1'b1);
        #1;
        chk("contend haddr",   rr_haddr,   32'h0000_0100);
        chk("contend hmaster", rr_hmaster, 0);
        chk("contend m1 rdy",  rr_rdy[1],  1'b1);
        cyc();
        set_m(0, T_IDLE, 32'h0, 1'b0);
        set_m(1, T_IDLE, 32'h0, 1'b0);
        m_hwdata[1] = 32'hA5A5_5A5A;
        #1;
        chk("replay haddr",   rr_haddr,   32'h2000_0000);
        chk("replay htrans",  rr_htrans,  T_NS);
        chk("replay hwrite",  rr_hwrite,  1'b1);
        chk("replay hmaster", rr_hmaster, 1);
        chk("replay m1 rdy",  rr_rdy[1],  1'b0);
        cyc();
        #1;
        chk("replay hwdata", rr_hwdata, 32'hA5A5_5A5A);
        chk("replay m1 rdy after", rr_rdy[1], 1'b1);
        chk("replay htrans after", rr_htrans, T_IDLE);
        cyc();
        m_hwdata[1] = 32'h0;

        // capture during a bus stall, issued on the first ready cycle
        do_reset();
        set_m(0, T_NS, 32'h0000_0010, 1'b0);
        cyc();
        set_m(0, T_IDLE, 32'h0, 1'b0);
        set_m(1, T_NS, 32'h4000_0000, 1'b0);
        hready = 1'b0;
        #1;
        chk("stall m1 rdy", rr_rdy[1], 1'b1);
        prev_t = rr_htrans;
        nchg   = 0;
        cyc();
        set_m(1, T_IDLE, 32'h0, 1'b0);
        for (int i = 1; i < 3; i++) begin
            #1;
            if (rr_htrans != prev_t) nchg++;
            if (prev_t[1] && !rr_htrans[1]) nchg += 10;
            prev_t = rr_htrans;
            chk("stall m1 held", rr_rdy[1], 1'b0);
            chk("stall m0 waits", rr_rdy[0], 1'b0);
            cyc();
        end
        chk("stall htrans changes", (nchg <= 1), 1'b1);
        hready = 1'b1;
        #1;
        chk("stall issue htrans",  rr_htrans,  T_NS);
        chk("stall issue haddr",   rr_haddr,   32'h4000_0000);
        chk("stall issue hmaster", rr_hmaster, 1);
        cyc();

        // back-to-back contention: RR alternates, fixed priority starves M1
        do_reset();
        set_m(0, T_NS, 32'h0000_0100, 1'b0);
        set_m(1, T_NS, 32'h0000_0200, 1'b0);
        n0 = 0; n1 = 0; alt_bad = 0; fp_bad = 0;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (rr_htrans[1]) begin
                if (rr_hmaster) n1++; else n0++;
            end
            if (rr_hmaster != i[0]) alt_bad++;
            if (fp_hmaster != 1'b0 || !fp_htrans[1]) fp_bad++;
            cyc();
        end
        chk("rr m0 grants", n0, 4);
        chk("rr m1 grants", n1, 4);
        chk("rr alternation errors", alt_bad, 0);
        chk("fp non-m0 grants", fp_bad, 0);
        set_m(0, T_IDLE, 32'h0, 1'b0);
        #1;
        chk("fp m1 after m0 idle", fp_hmaster, 1);
        chk("fp m1 addr", fp_haddr, 32'h0000_0200);
        cyc();
        set_m(1, T_IDLE, 32'h0, 1'b0);
        cyc();

        // reset drops a buffered request without replay
        do_reset();
        set_m(0, T_NS, 32'h0000_0100, 1'b0);
        set_m(1, T_NS, 32'h0000_0700, 1'b0);
        cyc();
        set_m(0, T_IDLE, 32'h0, 1'b0);
        set_m(1, T_IDLE, 32'h0, 1'b0);
        rst = 1'b1;
        #1;
        chk("rst mid htrans", rr_htrans, T_IDLE);
        chk("rst mid rdy",    rr_rdy,    2'b11);
        cyc();
        rst = 1'b0;
        #1;
        chk("post rst htrans",  rr_htrans,  T_IDLE);
        chk("post rst rdy",     rr_rdy,     2'b11);
        chk("post rst hmaster", rr_hmaster, 0);
        cyc();
        #1;
        chk("post rst no replay", rr_htrans, T_IDLE);
        cyc();

        // BUSY and IDLE never request or get captured
        do_reset();
        set_m(0, T_BUSY, 32'h0000_0500, 1'b0);
        #1;
        chk("busy htrans", rr_htrans, T_IDLE);
        chk("busy m0 rdy", rr_rdy[0], 1'b1);
        cyc();
        set_m(0, T_IDLE, 32'h0000_0504, 1'b0);
        #1;
        chk("idle htrans", rr_htrans, T_IDLE);
        chk("idle m0 rdy", rr_rdy[0], 1'b1);
        cyc();
        #1;
        chk("idle no capture", rr_rdy[0], 1'b1);
        cyc();

        // random traffic against the model
        do_reset();
        model_reset();
        acc[0] = 1'b1;
        acc[1] = 1'b1;
        for (int c = 0; c < 1500; c++) begin
            rst    = ($urandom_range(0, 99) < 3);
            hready = ($urandom_range(0, 99) < 70);
            hrdata = $urandom;
            for (int m = 0; m < 2; m++) begin
                if (acc[m]) begin
                    m_htrans[m] = 2'($urandom_range(0, 3));
                    m_haddr[m]  = $urandom & 32'hFFFF_FFFC;
                    m_hsize[m]  = 3'($urandom_range(0, 2));
                    m_hwrite[m] = 1'($urandom_range(0, 1));
                    m_hwdata[m] = $urandom;
                end
            end
            #1;
            rand_cycle();
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
